// File: rtl/uart_pkg.sv
// Shared constants and types for the UART receive path.
package uart_pkg;
  localparam int UART_DATA_W     = 8;
  localparam int UART_FIFO_DEPTH = 16;

  typedef struct packed {
    logic                   vld;
    logic [UART_DATA_W-1:0] data;
  } rx_beat_t;
endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [UART_DATA_W-1:0] wdata,
  input  logic [AW-1:0]          raddr,
  output logic [UART_DATA_W-1:0] rdata
);
  logic [DEPTH-1:0][UART_DATA_W-1:0] mem;

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// RX byte FIFO between the UART receive engine and MMIO: never stalls the
// engine, drops on full with a sticky overrun flag, level-threshold interrupt.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_FIFO_DEPTH,
  parameter int THRESH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [UART_DATA_W-1:0]   in_data,
  input  logic                     pop,
  output logic [UART_DATA_W-1:0]   rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     overrun,
  input  logic                     overrun_clr,
  input  logic                     flush,
  output logic                     thresh_irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  rx_beat_t      beat;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_q;
  logic          pop_ok, push_ok, drop, we;

  assign beat       = '{vld: in_valid, data: in_data};
  assign in_ready   = 1'b1;
  assign level      = level_q;
  assign rd_valid   = level_q != '0;
  assign full       = level_q == LW'(DEPTH);
  assign thresh_irq = level_q >= LW'(THRESH);

  // A pop on a full FIFO frees the slot the coincident push needs.
  assign pop_ok  = pop & rd_valid;
  assign push_ok = beat.vld & (~full | pop_ok);
  assign drop    = beat.vld & full & ~pop_ok & ~flush;
  assign we      = push_ok & ~flush & ~rst;

  uart_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (beat.data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      overrun <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        level_q <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
        case ({push_ok, pop_ok})
          2'b10:   level_q <= level_q + LW'(1);
          2'b01:   level_q <= level_q - LW'(1);
          default: level_q <= level_q;
        endcase
      end
      // Set beats clear when both happen in one cycle.
      if (drop)             overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized + directed check of uart_rx_fifo against a queue-based model.
module tb_uart_rx_fifo;
  localparam int DEPTH  = 16;
  localparam int THRESH = 8;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, pop, rd_valid, full, overrun;
  logic       overrun_clr, flush, thresh_irq;
  logic [7:0] in_data, rd_data;
  logic [4:0] level;

  byte unsigned q[$];
  bit           m_ovr;
  int           n_chk, n_fail;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(DEPTH), .THRESH(THRESH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .pop(pop), .rd_data(rd_data), .rd_valid(rd_valid),
    .level(level), .full(full), .overrun(overrun), .overrun_clr(overrun_clr),
    .flush(flush), .thresh_irq(thresh_irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_outputs();
    chk("level",      32'(level),      32'(q.size()));
    chk("rd_valid",   32'(rd_valid),   32'(q.size() != 0));
    chk("full",       32'(full),       32'(q.size() == DEPTH));
    chk("thresh_irq", 32'(thresh_irq), 32'(q.size() >= THRESH));
    chk("overrun",    32'(overrun),    32'(m_ovr));
    chk("in_ready",   32'(in_ready),   32'd1);
    if (q.size() != 0) chk("rd_data", 32'(rd_data), 32'(q[0]));
  endtask

  // One clock: apply inputs, check the pre-edge state, then advance the model.
  task automatic step(input bit r, input bit v, input byte unsigned d,
                      input bit p, input bit f, input bit c);
    bit popped, dropped;
    rst = r; in_valid = v; in_data = d; pop = p; flush = f; overrun_clr = c;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    if (r) begin
      q.delete();
      m_ovr = 1'b0;
    end else begin
      dropped = 1'b0;
      if (f) q.delete();
      else begin
        popped = p && q.size() != 0;
        if (v && !(q.size() < DEPTH || popped)) dropped = 1'b1;
        if (popped) void'(q.pop_front());
        if (v && !dropped) q.push_back(d);
      end
      if (dropped) m_ovr = 1'b1;
      else if (c)  m_ovr = 1'b0;
    end
    #1;
  endtask

  task automatic idle();        step(0, 0, 8'h00, 0, 0, 0); endtask
  task automatic push(input byte unsigned d); step(0, 1, d, 0, 0, 0); endtask
  task automatic pop1();        step(0, 0, 8'h00, 1, 0, 0); endtask
  task automatic drain();
    while (q.size() != 0) pop1();
    idle();
  endtask

  initial begin
    n_chk = 0; n_fail = 0; m_ovr = 1'b0;
    rst = 1'b1; in_valid = 0; in_data = 0; pop = 0; flush = 0; overrun_clr = 0;
    repeat (2) @(posedge clk);
    #1;
    idle();

    // ordered read-back
    push(8'h11); push(8'h22); push(8'h33);
    pop1(); pop1(); pop1(); idle();

    // fill past full; last byte dropped
    for (int i = 0; i < 17; i++) push(byte'(i));
    idle();
    chk("ovr_after_fill", 32'(overrun), 32'd1);
    drain();
    step(0, 0, 8'h00, 0, 0, 1);

    // full with coincident push/pop
    for (int i = 0; i < 16; i++) push(byte'(8'h40 + i));
    step(0, 1, 8'hAA, 1, 0, 0);
    idle();
    chk("full_pushpop_ovr", 32'(overrun), 32'd0);
    drain();

    // threshold
    for (int i = 0; i < 8; i++) push(byte'(8'h80 + i));
    idle();
    pop1(); idle();
    drain();

    // wrap pointers, then flush with a coincident push
    for (int i = 0; i < 20; i++) begin push(byte'(i * 3)); pop1(); end
    push(8'h01); push(8'h02); push(8'h03);
    step(0, 1, 8'h04, 0, 1, 0);
    idle();
    push(8'h5A); idle(); pop1(); idle();

    // overrun clear racing a drop, clear alone, reset mid-fill
    for (int i = 0; i < 16; i++) push(byte'(8'hC0 + i));
    push(8'hEE);
    step(0, 1, 8'hEF, 0, 0, 1);
    idle();
    chk("clr_vs_drop", 32'(overrun), 32'd1);
    step(0, 0, 8'h00, 0, 0, 1);
    idle();
    chk("clr_alone", 32'(overrun), 32'd0);
    drain();
    push(8'h01); push(8'h02); push(8'h03);
    step(1, 1, 8'h04, 1, 0, 0);
    idle();
    chk("rst_midfill_level", 32'(level), 32'd0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 99) < 60,
           byte'($urandom_range(0, 255)),
           $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) == 0,
           $urandom_range(0, 19) == 0);
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
